// File: rtl/adpll_clk_pkg.sv
// Shared constants, control encoding and helpers for the ADPLL clock-tree dividers.
package adpll_clk_pkg;

  localparam int DIV_WIDTH_DEF = 8;
  localparam int TAPS_DEF      = 3;
  localparam int DEFAULT_DIV   = 8;

  typedef enum logic [1:0] {
    CTL_HOLD    = 2'd0,
    CTL_RUN     = 2'd1,
    CTL_STOPPED = 2'd2,
    CTL_RESTART = 2'd3
  } ctl_e;

  // ceil(n/2) = (n>>1) + n[0]; callers truncate back to their own width.
  function automatic logic [31:0] ceil_half(input logic [31:0] n);
    return (n >> 1) + {31'd0, n[0]};
  endfunction

endpackage

// File: rtl/div_tap_counter.sv
// Free-running up counter with synchronous clear; each bit is a 50% power-of-two tap.
module div_tap_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_cnt;

  // Clear wins over enable so a restart realigns the taps even while frozen.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i) begin
      r_cnt <= r_cnt + ONE;
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/prog_clk_divider.sv
// Programmable divide-by-N pulse/square generator plus power-of-two taps, all in the
// clk_i domain; a new divisor is only adopted at the end of a period.
module prog_clk_divider #(
  parameter int WIDTH       = adpll_clk_pkg::DIV_WIDTH_DEF,
  parameter int TAPS        = adpll_clk_pkg::TAPS_DEF,
  parameter int DEFAULT_DIV = adpll_clk_pkg::DEFAULT_DIV
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             restart_i,
  input  logic [WIDTH-1:0] div_i,
  output logic             pulse_o,
  output logic             sq_o,
  output logic [TAPS-1:0]  taps_o,
  output logic [WIDTH-1:0] div_act_o
);

  import adpll_clk_pkg::*;

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_n;
  logic             r_pulse;
  logic             r_sq;

  ctl_e             w_ctl;
  logic             w_wrap;
  logic [WIDTH-1:0] w_cnt_nx;
  logic [WIDTH-1:0] w_n_nx;
  logic [WIDTH-1:0] w_half;
  logic [WIDTH-1:0] w_cnt_next;
  logic [WIDTH-1:0] w_n_next;
  logic             w_pulse_next;
  logic             w_sq_next;
  logic [TAPS-1:0]  w_taps;

  always_comb begin
    if (restart_i) begin
      w_ctl = CTL_RESTART;
    end else if (en_i) begin
      w_ctl = (r_n == '0) ? CTL_STOPPED : CTL_RUN;
    end else begin
      w_ctl = CTL_HOLD;
    end
  end

  // Running-period arithmetic; only meaningful when r_n != 0.
  always_comb begin
    w_wrap   = (r_cnt == (r_n - ONE));
    w_cnt_nx = w_wrap ? '0 : (r_cnt + ONE);
    w_n_nx   = w_wrap ? div_i : r_n;
    w_half   = WIDTH'(ceil_half(32'(w_n_nx)));
  end

  always_comb begin
    w_cnt_next   = r_cnt;
    w_n_next     = r_n;
    w_pulse_next = 1'b0;
    w_sq_next    = r_sq;
    case (w_ctl)
      CTL_RESTART: begin
        w_cnt_next = '0;
        w_n_next   = div_i;
        w_sq_next  = (div_i != '0);
      end
      CTL_STOPPED: begin
        w_cnt_next = '0;
        w_sq_next  = 1'b0;
      end
      CTL_RUN: begin
        w_cnt_next   = w_cnt_nx;
        w_n_next     = w_n_nx;
        w_pulse_next = (w_cnt_nx == '0) && (w_n_nx != '0);
        w_sq_next    = (w_cnt_nx < w_half);
      end
      default: begin
        w_cnt_next = r_cnt;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_cnt   <= '0;
      r_n     <= RST_DIV;
      r_pulse <= 1'b0;
      r_sq    <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_next;
      r_n     <= w_n_next;
      r_pulse <= w_pulse_next;
      r_sq    <= w_sq_next;
    end
  end

  div_tap_counter #(
    .WIDTH (TAPS)
  ) u_taps (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (en_i),
    .clr_i   (restart_i),
    .cnt_o   (w_taps)
  );

  assign pulse_o   = r_pulse;
  assign sq_o      = r_sq;
  assign taps_o    = w_taps;
  assign div_act_o = r_n;

endmodule

// File: tb/tb_prog_clk_divider.sv
// Scoreboard bench for prog_clk_divider: directed steps queue expected outputs, a monitor checks them.
module tb_prog_clk_divider;

  typedef struct {
    logic       pulse;
    logic       sq;
    logic [2:0] taps;
    logic [7:0] act;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       en_i = 1'b0;
  logic       restart_i = 1'b0;
  logic [7:0] div_i = 8'd8;
  logic       pulse_o;
  logic       sq_o;
  logic [2:0] taps_o;
  logic [7:0] div_act_o;

  exp_t       exp_q[$];
  logic [2:0] exp_tap = 3'd0;
  int         n_checks = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  prog_clk_divider #(
    .WIDTH       (8),
    .TAPS        (3),
    .DEFAULT_DIV (8)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .en_i      (en_i),
    .restart_i (restart_i),
    .div_i     (div_i),
    .pulse_o   (pulse_o),
    .sq_o      (sq_o),
    .taps_o    (taps_o),
    .div_act_o (div_act_o)
  );

  // One clock edge: drive inputs at negedge and queue what the next posedge must produce.
  task automatic step(input logic en, input logic rs, input logic [7:0] dv,
                      input logic ep, input logic es, input logic [7:0] ea, input string nm);
    exp_t e;
    @(negedge clk);
    en_i = en;
    restart_i = rs;
    div_i = dv;
    if (rs) exp_tap = 3'd0;
    else if (en) exp_tap = exp_tap + 3'd1;
    e.pulse = ep;
    e.sq = es;
    e.taps = exp_tap;
    e.act = ea;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk or posedge reset_i);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (pulse_o !== e.pulse || sq_o !== e.sq || taps_o !== e.taps || div_act_o !== e.act) begin
          $display("FAIL %s: got pulse=%0b sq=%0b taps=%0d act=%0d, expected pulse=%0b sq=%0b taps=%0d act=%0d",
                   e.name, pulse_o, sq_o, taps_o, div_act_o, e.pulse, e.sq, e.taps, e.act);
        end else begin
          n_pass++;
          $display("ok   %s: pulse=%0b sq=%0b taps=%0d act=%0d", e.name, pulse_o, sq_o, taps_o, div_act_o);
        end
      end
    end
  end

  initial begin : stim
    exp_t e;
    // reset state, sampled while reset is still asserted
    step(1'b0, 1'b0, 8'd8, 1'b0, 1'b0, 8'd8, "reset");
    @(negedge clk);
    reset_i = 1'b0;

    // 1: N=8 from reset, pulses on edges 8,16,24, 4 high / 4 low
    for (int k = 1; k <= 24; k++)
      step(1'b1, 1'b0, 8'd8, (k % 8) == 0, (k % 8) < 4, 8'd8, $sformatf("t1 n8 k=%0d", k));

    // 2: request 5; current period of 8 completes first, then period 5 (3 high / 2 low)
    for (int k = 1; k <= 8; k++)
      step(1'b1, 1'b0, 8'd5, k == 8, (k == 8) || (k < 4), (k == 8) ? 8'd5 : 8'd8,
           $sformatf("t2 tail8 k=%0d", k));
    for (int j = 1; j <= 15; j++)
      step(1'b1, 1'b0, 8'd5, (j % 5) == 0, (j % 5) < 3, 8'd5, $sformatf("t2 n5 j=%0d", j));

    // 3: back to 8, then change to 3 at cnt=2; period 8 completes, then period 3
    for (int j = 1; j <= 5; j++)
      step(1'b1, 1'b0, 8'd8, j == 5, (j == 5) || (j < 3), (j == 5) ? 8'd8 : 8'd5,
           $sformatf("t3 to8 j=%0d", j));
    for (int k = 1; k <= 2; k++)
      step(1'b1, 1'b0, 8'd8, 1'b0, 1'b1, 8'd8, $sformatf("t3 n8 k=%0d", k));
    for (int k = 3; k <= 8; k++)
      step(1'b1, 1'b0, 8'd3, k == 8, (k == 8) || (k < 4), (k == 8) ? 8'd3 : 8'd8,
           $sformatf("t3 chg k=%0d", k));
    for (int j = 1; j <= 6; j++)
      step(1'b1, 1'b0, 8'd3, (j % 3) == 0, (j % 3) < 2, 8'd3, $sformatf("t3 n3 j=%0d", j));

    // 4: N=8 up to cnt=6, restart with 4 (en low: restart still wins)
    for (int j = 1; j <= 3; j++)
      step(1'b1, 1'b0, 8'd8, j == 3, (j == 3) || (j < 2), (j == 3) ? 8'd8 : 8'd3,
           $sformatf("t4 to8 j=%0d", j));
    for (int k = 1; k <= 6; k++)
      step(1'b1, 1'b0, 8'd8, 1'b0, k < 4, 8'd8, $sformatf("t4 n8 k=%0d", k));
    step(1'b0, 1'b1, 8'd4, 1'b0, 1'b1, 8'd4, "t4 restart4");
    for (int j = 1; j <= 8; j++)
      step(1'b1, 1'b0, 8'd4, (j % 4) == 0, (j % 4) < 2, 8'd4, $sformatf("t4 n4 j=%0d", j));

    // 5: enable low 3 cycles mid-period, then 1 cycle right after a pulse
    step(1'b1, 1'b0, 8'd4, 1'b0, 1'b1, 8'd4, "t5 j=1");
    for (int f = 1; f <= 3; f++)
      step(1'b0, 1'b0, 8'd4, 1'b0, 1'b1, 8'd4, $sformatf("t5 frozen f=%0d", f));
    for (int j = 2; j <= 4; j++)
      step(1'b1, 1'b0, 8'd4, j == 4, j == 4, 8'd4, $sformatf("t5 j=%0d", j));
    step(1'b0, 1'b0, 8'd4, 1'b0, 1'b1, 8'd4, "t5 frozen after pulse");
    for (int j = 5; j <= 8; j++)
      step(1'b1, 1'b0, 8'd4, (j % 4) == 0, (j % 4) < 2, 8'd4, $sformatf("t5 j=%0d", j));

    // 6: stop via restart 0; nonzero div_i alone does not leave the stopped state
    step(1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 8'd0, "t6 restart0");
    for (int k = 1; k <= 5; k++)
      step(1'b1, 1'b0, 8'd3, 1'b0, 1'b0, 8'd0, $sformatf("t6 stopped k=%0d", k));
    step(1'b1, 1'b1, 8'd1, 1'b0, 1'b1, 8'd1, "t6 restart1");
    for (int k = 1; k <= 4; k++)
      step(1'b1, 1'b0, 8'd1, 1'b1, 1'b1, 8'd1, $sformatf("t6 n1 k=%0d", k));
    step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, "t6 latch0 at wrap");
    step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, "t6 stopped after latch");
    step(1'b1, 1'b1, 8'd6, 1'b0, 1'b1, 8'd6, "t6 restart6");
    for (int k = 1; k <= 3; k++)
      step(1'b1, 1'b0, 8'd6, 1'b0, k < 3, 8'd6, $sformatf("t6 n6 k=%0d", k));

    // async reset mid-period: outputs clear before any clock edge
    @(negedge clk);
    en_i = 1'b0;
    #2;
    e.pulse = 1'b0;
    e.sq = 1'b0;
    e.taps = 3'd0;
    e.act = 8'd8;
    e.name = "t6 async reset";
    exp_q.push_back(e);
    exp_tap = 3'd0;
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    for (int k = 1; k <= 8; k++)
      step(1'b1, 1'b0, 8'd8, k == 8, (k % 8) < 4, 8'd8, $sformatf("t6 post-reset k=%0d", k));

    // drain, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations pending, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
